uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART RX datapath. Synchronises the serial line, detects the start bit, times mid-bit sampling with a per-bit clock counter, and issues one-cycle strobes to the external shift register and the parity/stop checks. Sits between the rx pin and the SIPO/checker datapath; the datapath holds no timing logic of its own.

---
 rtl/uart_rx_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: start detect, mid-bit timing, datapath strobes
//
// Purpose: synchronises rx_i, detects a start bit, times mid-bit sampling with a
// per-bit clock counter and issues one-cycle strobes to the external SIPO and
// the parity/stop checks. All strobes are registered.
//
// Build option: define UART_RX_PARITY_EN to add one even-parity bit after the
// data bits (PARITY state + running parity register). When it is undefined,
// parity_err is tied low.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx_i       in   serial line (idle high, start low, stop high)
//   shift_en   out  one-cycle strobe: SIPO shifts in sample_o
//   sample_o   out  sampled bit value, valid while shift_en=1
//   data_last  out  high with the final data-bit shift_en
//   parity_err out  one-cycle pulse at the parity sample on mismatch
//   frame_done out  one-cycle pulse: stop bit sampled high
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   busy       out  high whenever the sequencer is not idle

module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic shift_en,
  output logic sample_o,
  output logic data_last,
  output logic parity_err,
  output logic frame_done,
  output logic frame_err,
  output logic busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          armed_q, armed_d;
  logic          shift_en_q, shift_en_d;
  logic          sample_q, sample_d;
  logic          data_last_q, data_last_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          parity_err_q, parity_err_d;
`endif

  // Mid-bit point: the counter wraps once per bit, and the START half-bit
  // offset places every wrap at the centre of a bit cell.
  logic cnt_wrap;
  assign cnt_wrap = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    armed_d      = armed_q;
    shift_en_d   = 1'b0;
    sample_d     = 1'b0;
    data_last_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Arming requires seeing the line high first, so a held-low break
        // cannot start a new frame.
        if (rx_s_q) armed_d = 1'b1;
        if (armed_q && !rx_s_q) begin
          state_d = ST_START;
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end

      ST_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            idx_d   = '0;
`ifdef UART_RX_PARITY_EN
            par_d   = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
        if (cnt_wrap) begin
          shift_en_d = 1'b1;
          sample_d   = rx_s_q;
          idx_d      = idx_q + IW'(1);
`ifdef UART_RX_PARITY_EN
          par_d      = par_q ^ rx_s_q;
`endif
          if (idx_q == IDX_LAST) begin
            data_last_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            state_d     = ST_PARITY;
`else
            state_d     = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
        if (cnt_wrap) begin
          parity_err_d = par_q ^ rx_s_q;
          state_d      = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        cnt_d = cnt_wrap ? '0 : cnt_q + CW'(1);
        if (cnt_wrap) begin
          frame_done_d = rx_s_q;
          frame_err_d  = !rx_s_q;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      armed_q      <= 1'b0;
      shift_en_q   <= 1'b0;
      sample_q     <= 1'b0;
      data_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_i;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      armed_q      <= armed_d;
      shift_en_q   <= shift_en_d;
      sample_q     <= sample_d;
      data_last_q  <= data_last_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign shift_en   = shift_en_q;
  assign sample_o   = sample_q;
  assign data_last  = data_last_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl

module tb_uart_rx_ctrl;

  localparam int CPB = 16;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Pin change to visible first-sample strobe: 2 sync flops, 1 strobe register,
  // then 1.5 bit periods to the centre of data bit 0.
  localparam int FIRST = 2 + 1 + CPB + CPB / 2;

  localparam logic [1:0] K_SHIFT = 2'd0;
  localparam logic [1:0] K_DONE  = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;
  localparam logic [1:0] K_PAR   = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_i = 1'b1;
  logic shift_en, sample_o, data_last, parity_err, frame_done, frame_err, busy;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i),
    .shift_en(shift_en), .sample_o(sample_o), .data_last(data_last),
    .parity_err(parity_err), .frame_done(frame_done), .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [3:0] code;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic ev_t mk_ev(input int t, input logic [3:0] code);
    ev_t e;
    e.t    = t;
    e.code = code;
    return e;
  endfunction

  // Observed strobe log, sampled mid-cycle.
  always @(negedge clk) begin
    if (shift_en)   obs_q.push_back(mk_ev(cyc, {K_SHIFT, sample_o, data_last}));
    if (frame_done) obs_q.push_back(mk_ev(cyc, {K_DONE, 2'b00}));
    if (frame_err)  obs_q.push_back(mk_ev(cyc, {K_ERR, 2'b00}));
    if (parity_err) obs_q.push_back(mk_ev(cyc, {K_PAR, 2'b00}));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: a frame whose start bit hits the pin at t0 yields one strobe
  // per bit centre, CPB cycles apart.
  function automatic void model_frame(input int t0, input logic [8:0] d,
                                      input logic par_b, input logic stop_b);
    int t;
    for (int k = 0; k < DB; k++)
      exp_q.push_back(mk_ev(t0 + FIRST + CPB * k, {K_SHIFT, d[k], (k == DB - 1)}));
    t = t0 + FIRST + CPB * DB;
    if (PB == 1) begin
      if (((^d[DB-1:0]) ^ par_b) != 1'b0) exp_q.push_back(mk_ev(t, {K_PAR, 2'b00}));
      t = t + CPB;
    end
    exp_q.push_back(mk_ev(t, {(stop_b ? K_DONE : K_ERR), 2'b00}));
  endfunction

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input logic par_b, input logic stop_b);
    model_frame(cyc, d, par_b, stop_b);
    send_bit(1'b0);
    for (int k = 0; k < DB; k++) send_bit(d[k]);
    if (PB == 1) send_bit(par_b);
    send_bit(stop_b);
  endtask

  task automatic compare_events(input string tag);
    int n;
    #1;
    check({tag, " event count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s ev%0d time", tag, i), obs_q[i].t, exp_q[i].t);
      check($sformatf("%s ev%0d code", tag, i), obs_q[i].code, exp_q[i].code);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [6:0] outs();
    return {shift_en, sample_o, data_last, parity_err, frame_done, frame_err, busy};
  endfunction

  initial begin
    logic [8:0] d;
    logic       bad, par_b;
    int         t0, gap;

    // Reset state
    rst  = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("reset outputs", outs(), 7'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle busy", busy, 1'b0);

    // Single frame 0xA5
    send_frame(9'h0A5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    compare_events("frame a5");
    check("a5 busy after", busy, 1'b0);

    // Glitch shorter than half a bit: false start
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (12) @(negedge clk);
    compare_events("glitch");
    check("glitch busy", busy, 1'b0);
    repeat (4) @(negedge clk);

    // Stop bit low, then a long break, then recovery
    send_frame(9'h03C, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (200) @(negedge clk);
    compare_events("stop low + break");
    check("break busy", busy, 1'b0);
    rx_i = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(9'h055, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    compare_events("after break 55");

`ifdef UART_RX_PARITY_EN
    send_frame(9'h007, 1'b1, 1'b1);
    send_frame(9'h007, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    compare_events("parity");
`endif

    // Back-to-back frames, no idle gap
    send_frame(9'h000, 1'b0, 1'b1);
    send_frame(9'h0FF, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    compare_events("back to back");

    // Reset during data bit 3 of 0x81 (LSB first: 1,0,0,0,...)
    t0 = cyc;
    for (int k = 0; k < 3; k++)
      exp_q.push_back(mk_ev(t0 + FIRST + CPB * k, {K_SHIFT, (k == 0), 1'b0}));
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1 check("mid-frame reset outputs", outs(), 7'd0);
    repeat (2) @(negedge clk);
    check("reset held outputs", outs(), 7'd0);
    rx_i = 1'b1;
    rst  = 1'b0;
    compare_events("partial before reset");
    repeat (10) @(negedge clk);
    send_frame(9'h081, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    compare_events("after reset 81");

    // Random frames with random gaps, bad stops and bad parity
    for (int i = 0; i < 8; i++) begin
      d     = 9'($urandom_range(0, 255));
      bad   = ($urandom_range(0, 3) == 0);
      par_b = (^d[DB-1:0]) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, par_b, !bad);
      rx_i = 1'b1;
      gap  = bad ? $urandom_range(1, 20) : $urandom_range(0, 20);
      repeat (gap) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    compare_events("random");
    check("final busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
